multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style multicycle control FSM for the ARM-subset processor.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, memory port and register file.
- Drives the immediate-extend select (imm_src_o), the ALU operand muxes, the memory and register write enables, and the architectural NZCV flags register.
- Sits beside the datapath; consumes the instruction register and the ALU flags.

Parameters:
- MEM_WAIT_CYCLES, default 0: extra cycles held in MEMRD before MEMWB (0..15).

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- instr_i  in  32  instruction register contents: cond[31:28], op[27:26], I[25], U[23], cmd[24:21], S/L[20], Rd[15:12]
- alu_flags_i  in  4  ALU NZCV of the current operation
- pc_write_o  out  1  PC load enable
- adr_src_o  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write_o  out  1  data memory write enable
- ir_write_o  out  1  instruction register load enable
- reg_write_o  out  1  register file write enable
- result_src_o  out  2  result mux: 00=ALUOut, 01=read data, 10=ALU result
- alu_src_a_o  out  1  0=register A, 1=PC
- alu_src_b_o  out  2  00=register B, 01=extended immediate, 10=constant 4
- alu_control_o  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- imm_src_o  out  2  extend select: 00=8-bit DP imm, 01=12-bit mem offset, 10=24-bit branch
- flags_o  out  4  architectural NZCV register
- state_o  out  4  current state code (debug)

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10..15 are unreachable; if entered, next state is FETCH.
- Reset (async, any state):
  - state=FETCH, flags_o=0, wait counter=0.
  - While rst_i is high, all enables (pc/ir/reg/mem write) are forced to 0.
- imm_src_o is combinational from op: 00→00, 01→01, 10→10, 11→00.
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10, ir_write=1, pc_write=1. Next state: DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, ADD, result_src=10 (PC+8). Next state by op:
  - op=01: MEMADR
  - op=00 with I=1: EXECI
  - op=00 with I=0: EXECR
  - op=10: BRANCH
  - op=11 (undefined): FETCH, no writes
- MEMADR: alu_src_a=0, alu_src_b=01; ADD if U=1, else SUB. Next state: MEMRD if L=1, else MEMWR.
- MEMRD: adr_src=1, result_src=00.
  - Holds while the wait counter is below MEM_WAIT_CYCLES; the counter increments each cycle.
  - Then goes to MEMWB with the counter cleared.
- MEMWB: result_src=01, reg_write=1; pc_write=1 if Rd=15. Next state: FETCH.
- MEMWR: adr_src=1, result_src=00, mem_write=1 for exactly one cycle. Next state: FETCH.
- EXECR / EXECI: alu_src_a=0; alu_src_b=00 (EXECR) or 01 (EXECI). Next state: ALUWB.
  - ALU op from cmd: 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR, 1010 (CMP)→SUB.
  - Any other cmd→ADD.
- ALUWB: result_src=00; keeps the same alu_control_o as the preceding EXEC state. Next state: FETCH.
  - reg_write=1 unless cmd=CMP; pc_write=1 if Rd=15 and not CMP.
  - flags_o <= alu_flags_i at the clock edge leaving ALUWB when S=1 or cmd=CMP.
- BRANCH: alu_src_a=0, alu_src_b=01, ADD, result_src=10, pc_write=1. Next state: FETCH.
- Default for every output not listed in a state is 0.
- Latencies (including FETCH): DP=4 cycles, branch=3, store=4, load=5+MEM_WAIT_CYCLES.

Optional Feature:
- Macro: COND_EXEC_EN.
- Defined:
  - In DECODE, cond is evaluated against flags_o per the ARM table (EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 false).
  - A failing cond returns to FETCH with no register, memory, PC or flags write.
- Undefined: cond is ignored and every instruction executes.

Test Plan:
- Reset asserted mid-MEMRD (instr E5903008, MEM_WAIT_CYCLES=3) → state_o=0 immediately and all enables 0; after release, FETCH with ir_write_o=1.
- ADD R1,R2,#5 (E2821005) → states 0,1,7,8; imm_src_o=00, alu_src_b_o=01 in EXECI; reg_write_o=1 only in ALUWB; flags_o unchanged.
- LDR R3,[R0,#8] (E5903008), MEM_WAIT_CYCLES=2 → states 0,1,2,3,3,3,4; imm_src_o=01; reg_write_o=1 with result_src_o=01 in MEMWB. STR (E5803008) → mem_write_o high exactly one cycle in state 5.
- CMP R1,R2 (E1510002) with alu_flags_i=0100 → no reg_write_o; flags_o=0100 after ALUWB.
- B (EA000002) → states 0,1,9; imm_src_o=10; pc_write_o=1 in BRANCH.
- COND_EXEC_EN defined, flags_o Z=0, BEQ (0A000001) → DECODE then FETCH, pc_write_o=0 in DECODE; with Z=1 → BRANCH taken.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Interface between the multicycle control FSM and the datapath of the
// ARM-subset processor. The datapath (master) supplies the instruction
// register and ALU flags. The controller (slave) returns the control strobes,
// the architectural NZCV register and a debug state code.
interface multicycle_control_if;
  logic [31:0] instr_i;
  logic [3:0]  alu_flags_i;
  logic        pc_write_o;
  logic        adr_src_o;
  logic        mem_write_o;
  logic        ir_write_o;
  logic        reg_write_o;
  logic [1:0]  result_src_o;
  logic        alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [1:0]  alu_control_o;
  logic [1:0]  imm_src_o;
  logic [3:0]  flags_o;
  logic [3:0]  state_o;

  modport master (
    output instr_i, alu_flags_i,
    input  pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o,
    input  result_src_o, alu_src_a_o, alu_src_b_o, alu_control_o,
    input  imm_src_o, flags_o, state_o
  );

  modport slave (
    input  instr_i, alu_flags_i,
    output pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o,
    output result_src_o, alu_src_a_o, alu_src_b_o, alu_control_o,
    output imm_src_o, flags_o, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore multicycle control FSM for the ARM-subset processor.
// It sequences FETCH/DECODE/EXEC/MEM/WB over the shared ALU, memory and
// register file. It also owns the architectural NZCV flags register.
// MEM_WAIT_CYCLES adds hold cycles in MEMRD (0..15).
// Optional macro COND_EXEC_EN enables ARM condition-code evaluation in DECODE.
// When the macro is undefined, the cond field is ignored.
module multicycle_control #(
  parameter int MEM_WAIT_CYCLES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multicycle_control_if.slave  bus
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] WAIT_MAX = MEM_WAIT_CYCLES[3:0];

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [3:0] r_wait_cnt;
  logic [3:0] r_flags;

  // Instruction field decode
  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic       w_imm_bit;
  logic       w_up;
  logic [3:0] w_cmd;
  logic       w_sl;
  logic       w_rd_pc;
  logic       w_is_cmp;
  logic [1:0] w_dp_alu;
  logic       w_cond_ok;
  logic       w_unused_bits;

  assign w_cond    = bus.instr_i[31:28];
  assign w_op      = bus.instr_i[27:26];
  assign w_imm_bit = bus.instr_i[25];
  assign w_up      = bus.instr_i[23];
  assign w_cmd     = bus.instr_i[24:21];
  assign w_sl      = bus.instr_i[20];
  assign w_rd_pc   = (bus.instr_i[15:12] == 4'hF);
  assign w_is_cmp  = (w_cmd == 4'b1010);
  assign w_unused_bits = &{1'b0, w_cond, bus.instr_i[22], bus.instr_i[19:16], bus.instr_i[11:0]};

`ifdef COND_EXEC_EN
  // ARM condition evaluation against NZCV = {N, Z, C, V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign w_cond_ok = cond_pass(w_cond, r_flags);
`else
  assign w_cond_ok = 1'b1;
`endif

  // Data-processing ALU operation from cmd; shared by EXEC and ALUWB
  always_comb begin
    case (w_cmd)
      4'b0100: w_dp_alu = ALU_ADD;
      4'b0010: w_dp_alu = ALU_SUB;
      4'b0000: w_dp_alu = ALU_AND;
      4'b1100: w_dp_alu = ALU_ORR;
      4'b1010: w_dp_alu = ALU_SUB;
      default: w_dp_alu = ALU_ADD;
    endcase
  end

  // State register with async reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // MEMRD wait counter: counts while holding, cleared everywhere else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait_cnt <= 4'd0;
    end else if ((r_state == S_MEMRD) && (r_wait_cnt < WAIT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  // Architectural flags: captured when leaving ALUWB for S=1 or CMP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_flags <= 4'd0;
    end else if ((r_state == S_ALUWB) && (w_sl || w_is_cmp)) begin
      r_flags <= bus.alu_flags_i;
    end else begin
      r_flags <= r_flags;
    end
  end

  // Next-state logic; unreachable codes recover to FETCH
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        if (!w_cond_ok) begin
          w_next_state = S_FETCH;
        end else begin
          case (w_op)
            2'b01:   w_next_state = S_MEMADR;
            2'b00:   w_next_state = w_imm_bit ? S_EXECI : S_EXECR;
            2'b10:   w_next_state = S_BRANCH;
            default: w_next_state = S_FETCH;
          endcase
        end
      end
      S_MEMADR: w_next_state = w_sl ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next_state = (r_wait_cnt < WAIT_MAX) ? S_MEMRD : S_MEMWB;
      S_EXECR:  w_next_state = S_ALUWB;
      S_EXECI:  w_next_state = S_ALUWB;
      default:  w_next_state = S_FETCH;
    endcase
  end

  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_control;

  // Moore output decode from the current state
  always_comb begin
    w_pc_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_result_src  = 2'b00;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_control = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = 1'b1;
        w_pc_write   = 1'b1;
      end
      S_DECODE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
      end
      S_MEMADR: begin
        w_alu_src_b   = 2'b01;
        w_alu_control = w_up ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: w_adr_src = 1'b1;
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_pc_write   = w_rd_pc;
      end
      S_MEMWR: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: w_alu_control = w_dp_alu;
      S_EXECI: begin
        w_alu_src_b   = 2'b01;
        w_alu_control = w_dp_alu;
      end
      S_ALUWB: begin
        w_alu_control = w_dp_alu;
        w_reg_write   = ~w_is_cmp;
        w_pc_write    = w_rd_pc & ~w_is_cmp;
      end
      S_BRANCH: begin
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_pc_write   = 1'b1;
      end
      default: w_pc_write = 1'b0;
    endcase
  end

  // Extend select follows op directly, independent of state
  always_comb begin
    case (w_op)
      2'b01:   bus.imm_src_o = 2'b01;
      2'b10:   bus.imm_src_o = 2'b10;
      default: bus.imm_src_o = 2'b00;
    endcase
  end

  // Write enables are held off for the whole time reset is asserted
  assign bus.pc_write_o    = w_pc_write  & ~rst_i;
  assign bus.ir_write_o    = w_ir_write  & ~rst_i;
  assign bus.reg_write_o   = w_reg_write & ~rst_i;
  assign bus.mem_write_o   = w_mem_write & ~rst_i;
  assign bus.adr_src_o     = w_adr_src;
  assign bus.result_src_o  = w_result_src;
  assign bus.alu_src_a_o   = w_alu_src_a;
  assign bus.alu_src_b_o   = w_alu_src_b;
  assign bus.alu_control_o = w_alu_control;
  assign bus.flags_o       = r_flags;
  assign bus.state_o       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (MEM_WAIT_CYCLES=2).
// Each stimulus cycle pushes the hand-derived control word for that cycle.
// A negedge monitor pops each pushed word and compares it with the DUT outputs.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_w;
    logic       adr;
    logic       mem_w;
    logic       ir_w;
    logic       reg_w;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluc;
    logic [1:0] imm;
    logic [3:0] flags;
    logic [3:0] state;
  } ctl_t;

  logic clk_i = 1'b0;
  logic rst_i;
  multicycle_control_if bus();

  multicycle_control #(.MEM_WAIT_CYCLES(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  ctl_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  logic [1:0] cur_imm;
  logic [3:0] exp_flags;
  ctl_t  act;

  assign act = {bus.pc_write_o, bus.adr_src_o, bus.mem_write_o, bus.ir_write_o,
                bus.reg_write_o, bus.result_src_o, bus.alu_src_a_o, bus.alu_src_b_o,
                bus.alu_control_o, bus.imm_src_o, bus.flags_o, bus.state_o};

  // Expected control word per state, written from the state table
  function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [1:0] aluc,
                                   input logic regw, input logic pcw);
    ctl_t e;
    e = '0;
    e.imm   = cur_imm;
    e.flags = exp_flags;
    e.state = st;
    case (st)
      4'd0: begin e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10; e.ir_w = 1'b1; e.pc_w = 1'b1; end
      4'd1: begin e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10; end
      4'd2: begin e.srcb = 2'b01; e.aluc = aluc; end
      4'd3: e.adr = 1'b1;
      4'd4: begin e.res = 2'b01; e.reg_w = regw; e.pc_w = pcw; end
      4'd5: begin e.adr = 1'b1; e.mem_w = 1'b1; end
      4'd6: e.aluc = aluc;
      4'd7: begin e.srcb = 2'b01; e.aluc = aluc; end
      4'd8: begin e.aluc = aluc; e.reg_w = regw; e.pc_w = pcw; end
      4'd9: begin e.srcb = 2'b01; e.res = 2'b10; e.pc_w = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic cyc(input string tag, input logic [3:0] st, input logic [1:0] aluc,
                     input logic regw, input logic pcw);
    sb_q.push_back(exp_ctl(st, aluc, regw, pcw));
    tag_q.push_back(tag);
    @(posedge clk_i);
    #1;
  endtask

  // Cycle with reset held: FETCH decode, but every write enable off
  task automatic cyc_rst(input string tag);
    ctl_t e;
    e = exp_ctl(4'd0, 2'b00, 1'b0, 1'b0);
    e.pc_w = 1'b0;
    e.ir_w = 1'b0;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: compare the DUT against the oldest pending expectation
  always @(negedge clk_i) begin
    ctl_t  e;
    string t;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      if (act === e) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                 t, act, act.state, e, e.state);
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    bus.instr_i = 32'h0000_0000;
    bus.alu_flags_i = 4'b0000;
    cur_imm = 2'b00;
    exp_flags = 4'b0000;
    @(posedge clk_i);
    #1;
    cyc_rst("reset_state");
    rst_i = 1'b0;

    // LDR R3,[R0,#8] interrupted by reset mid-MEMRD
    bus.instr_i = 32'hE590_3008; cur_imm = 2'b01;
    cyc("ldr_fetch", 4'd0, 2'b00, 1'b0, 1'b0);
    cyc("ldr_decode", 4'd1, 2'b00, 1'b0, 1'b0);
    cyc("ldr_memadr", 4'd2, 2'b00, 1'b0, 1'b0);
    cyc("ldr_memrd0", 4'd3, 2'b00, 1'b0, 1'b0);
    rst_i = 1'b1;
    cyc_rst("rst_mid_memrd");
    rst_i = 1'b0;
    cyc("post_rst_fetch", 4'd0, 2'b00, 1'b0, 1'b0);
    cyc("ldr_decode2", 4'd1, 2'b00, 1'b0, 1'b0);
    cyc("ldr_memadr2", 4'd2, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("ldr_memrd_wait", 4'd3, 2'b00, 1'b0, 1'b0);
    cyc("ldr_memwb", 4'd4, 2'b00, 1'b1, 1'b0);

    // STR R3,[R0,#8] (U=1) and STR R3,[R0,#-8] (U=0)
    bus.instr_i = 32'hE580_3008;
    cyc("str_fetch", 4'd0, 2'b00, 1'b0, 1'b0);
    cyc("str_decode", 4'd1, 2'b00, 1'b0, 1'b0);
    cyc("str_memadr", 4'd2, 2'b00, 1'b0, 1'b0);
    cyc("str_memwr", 4'd5, 2'b00, 1'b0, 1'b0);
    bus.instr_i = 32'hE500_3008;
    cyc("strn_fetch", 4'd0, 2'b00, 1'b0, 1'b0);
    cyc("strn_decode", 4'd1, 2'b00, 1'b0, 1'b0);
    cyc("strn_memadr_sub", 4'd2, 2'b01, 1'b0, 1'b0);
    cyc("strn_memwr", 4'd5, 2'b00, 1'b0, 1'b0);

    // ADD R1,R2,#5: S=0, flags must not follow the ALU
    bus.instr_i = 32'hE282_1005; cur_imm = 2'b00; bus.alu_flags_i = 4'b1111;
    cyc("add_fetch", 4'd0, 2'b00, 1'b0, 1'b0);
    cyc("add_decode", 4'd1, 2'b00, 1'b0, 1'b0);
    cyc("add_execi", 4'd7, 2'b00, 1'b0, 1'b0);
    cyc("add_aluwb", 4'd8, 2'b00, 1'b1, 1'b0);

    // ANDS R15,R1,R2: register form, PC write, flags captured
    bus.instr_i = 32'hE011_F002; bus.alu_flags_i = 4'b0010;
    cyc("ands_fetch", 4'd0, 2'b00, 1'b0, 1'b0);
    cyc("ands_decode", 4'd1, 2'b00, 1'b0, 1'b0);
    cyc("ands_execr", 4'd6, 2'b10, 1'b0, 1'b0);
    cyc("ands_aluwb", 4'd8, 2'b10, 1'b1, 1'b1);
    exp_flags = 4'b0010;

    // BEQ with Z=0
    bus.instr_i = 32'h0A00_0001; cur_imm = 2'b10;
    cyc("beq_z0_fetch", 4'd0, 2'b00, 1'b0, 1'b0);
    cyc("beq_z0_decode", 4'd1, 2'b00, 1'b0, 1'b0);
`ifndef COND_EXEC_EN
    cyc("beq_z0_branch", 4'd9, 2'b00, 1'b0, 1'b0);
`endif

    // CMP R1,R2 with ALU Z set
    bus.instr_i = 32'hE151_0002; cur_imm = 2'b00; bus.alu_flags_i = 4'b0100;
    cyc("cmp_fetch", 4'd0, 2'b00, 1'b0, 1'b0);
    cyc("cmp_decode", 4'd1, 2'b00, 1'b0, 1'b0);
    cyc("cmp_execr", 4'd6, 2'b01, 1'b0, 1'b0);
    cyc("cmp_aluwb", 4'd8, 2'b01, 1'b0, 1'b0);
    exp_flags = 4'b0100;

    // B (always)
    bus.instr_i = 32'hEA00_0002; cur_imm = 2'b10; bus.alu_flags_i = 4'b0000;
    cyc("b_fetch", 4'd0, 2'b00, 1'b0, 1'b0);
    cyc("b_decode", 4'd1, 2'b00, 1'b0, 1'b0);
    cyc("b_branch", 4'd9, 2'b00, 1'b0, 1'b0);

    // BEQ with Z=1: taken in every build
    bus.instr_i = 32'h0A00_0001;
    cyc("beq_z1_fetch", 4'd0, 2'b00, 1'b0, 1'b0);
    cyc("beq_z1_decode", 4'd1, 2'b00, 1'b0, 1'b0);
    cyc("beq_z1_branch", 4'd9, 2'b00, 1'b0, 1'b0);
    cyc("final_fetch", 4'd0, 2'b00, 1'b0, 1'b0);

    @(negedge clk_i);
    #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
